// File: rtl/lif_osc_network.sv
// N-neuron leaky integrate-and-fire oscillator network with ring or all-to-all
// coupling, registered spike outputs and a saturating spike counter.
module lif_osc_network #(
    parameter int N          = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRACT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           mode,
    input  logic [N-1:0]   stim,
    input  logic [W-1:0]   stim_level,
    input  logic [W-1:0]   coup_weight,
    input  logic [W-1:0]   threshold,
    input  logic           count_clr,
    output logic [N-1:0]   spike,
    output logic           spike_any,
    output logic [7:0]     spike_count
);

    // Four guard bits cover v + stimulus + up to seven weighted coupling inputs.
    localparam int SW = W + 4;
    localparam logic [W-1:0] V_MAX     = '1;
    localparam logic [3:0]   REFR_INIT = 4'(REFRACT);

    function automatic logic [3:0] popcnt_skip(input logic [N-1:0] x, input int skip);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < N; k++) begin
            if (k != skip) c = c + 4'(x[k]);
        end
        return c;
    endfunction

    logic [W-1:0]  v        [N];
    logic [3:0]    refr     [N];
    logic [W-1:0]  v_nxt    [N];
    logic [3:0]    refr_nxt [N];
    logic [SW-1:0] coup     [N];
    logic [SW-1:0] sum      [N];
    logic [W-1:0]  sat      [N];
    logic [N-1:0]  spike_nxt;
    logic [8:0]    count_sum;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (mode)
                coup[i] = SW'(popcnt_skip(spike, i)) * SW'(coup_weight);
            else
                coup[i] = spike[(i + N - 1) % N] ? SW'(coup_weight) : '0;
            sum[i] = SW'(v[i]) - SW'(v[i] >> LEAK_SHIFT)
                   + (stim[i] ? SW'(stim_level) : '0) + coup[i];
            sat[i] = (sum[i] > SW'(V_MAX)) ? V_MAX : sum[i][W-1:0];
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        spike_nxt = '0;
        for (int i = 0; i < N; i++) begin
            v_nxt[i]    = v[i];
            refr_nxt[i] = refr[i];
            if (ena) begin
                if (refr[i] != 4'd0) begin
                    refr_nxt[i] = refr[i] - 4'd1;
                    v_nxt[i]    = '0;
                end else if (threshold != '0 && sat[i] >= threshold) begin
                    spike_nxt[i] = 1'b1;
                    v_nxt[i]     = '0;
                    refr_nxt[i]  = REFR_INIT;
                end else begin
                    v_nxt[i] = sat[i];
                end
            end
        end
    end

    assign count_sum = {1'b0, spike_count} + 9'(popcnt_skip(spike, -1));

    // NOTE: the membrane and refractory arrays are a handful of flops, not a
    // RAM, so they take the async reset like any other state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                v[i]    <= '0;
                refr[i] <= '0;
            end
            spike <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every neuron reading the
            // previous cycle's spike vector regardless of statement order.
            for (int i = 0; i < N; i++) begin
                v[i]    <= v_nxt[i];
                refr[i] <= refr_nxt[i];
            end
            spike <= spike_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spike_count <= '0;
        else if (count_clr)
            spike_count <= '0;
        else if (ena)
            spike_count <= count_sum[8] ? 8'hFF : count_sum[7:0];
    end

    assign spike_any = |spike;

endmodule

// File: tb/tb_lif_osc_network.sv
// Scoreboard bench for lif_osc_network: an integer reference model predicts
// spike and count for every edge, plus fixed expectations for key scenarios.
module tb_lif_osc_network;

    logic       clk = 1'b0;
    logic       rst_n, ena, mode, count_clr;
    logic [3:0] stim;
    logic [7:0] stim_level, coup_weight, threshold;
    logic [3:0] spike;
    logic       spike_any;
    logic [7:0] spike_count;

    always #5 clk = ~clk;

    lif_osc_network #(.N(4), .W(8), .LEAK_SHIFT(4), .REFRACT(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .stim(stim),
        .stim_level(stim_level), .coup_weight(coup_weight), .threshold(threshold),
        .count_clr(count_clr), .spike(spike), .spike_any(spike_any),
        .spike_count(spike_count)
    );

    typedef struct packed {
        logic [3:0] spk;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int         mv[4];
    int         mr[4];
    logic [3:0] ms;
    int         mc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
        ms = '0;
        mc = 0;
    endtask

    task automatic model_step();
        logic [3:0] ns;
        int c, s;
        ns = '0;
        if (count_clr) mc = 0;
        else if (ena) mc = (mc + $countones(ms) > 255) ? 255 : mc + $countones(ms);
        if (ena) begin
            for (int i = 0; i < 4; i++) begin
                if (mode) c = $countones(ms & ~(4'b0001 << i)) * int'(coup_weight);
                else      c = ms[(i + 3) % 4] ? int'(coup_weight) : 0;
                if (mr[i] > 0) begin
                    mr[i] = mr[i] - 1;
                    mv[i] = 0;
                end else begin
                    s = mv[i] - mv[i] / 16 + (stim[i] ? int'(stim_level) : 0) + c;
                    if (s > 255) s = 255;
                    if (threshold != 0 && s >= int'(threshold)) begin
                        ns[i] = 1'b1;
                        mv[i] = 0;
                        mr[i] = 2;
                    end else begin
                        mv[i] = s;
                    end
                end
            end
        end
        ms = ns;
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.spk = ms;
        e.cnt = 8'(mc);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("spike", 32'(spike), 32'(e.spk));
            check("spike_any", 32'(spike_any), 32'(|e.spk));
            check("spike_count", 32'(spike_count), 32'(e.cnt));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic setup(input logic m, input logic [3:0] st, input logic [7:0] lvl,
                         input logic [7:0] cw, input logic [7:0] thr);
        mode = m; stim = st; stim_level = lvl; coup_weight = cw; threshold = thr;
        ena = 1'b1; count_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; mode = 1'b0; count_clr = 1'b0;
        stim = '0; stim_level = '0; coup_weight = '0; threshold = '0;
        model_reset();
        #3;
        check("rst_spike", 32'(spike), 0);
        check("rst_count", 32'(spike_count), 0);
        #8;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single neuron: v = 64,124,181 then spike on the 4th edge, period 6.
        setup(1'b0, 4'b0001, 8'd64, 8'd0, 8'd200);
        for (int k = 0; k < 3; k++) step();
        check("t2_no_early_spike", 32'(spike), 0);
        step();
        check("t2_first_spike", 32'(spike), 32'h1);
        for (int k = 0; k < 6; k++) step();
        check("t2_second_spike", 32'(spike), 32'h1);
        step();
        check("t2_count", 32'(spike_count), 2);

        // Ring: one-cycle kick on neuron 0 then sustained rotation.
        do_reset();
        setup(1'b0, 4'b0001, 8'd200, 8'd255, 8'd200);
        step();
        check("t3_kick", 32'(spike), 32'h1);
        stim = '0;
        step();
        check("t3_n1", 32'(spike), 32'h2);
        step();
        check("t3_n2", 32'(spike), 32'h4);
        step();
        check("t3_n3", 32'(spike), 32'h8);
        step();
        check("t3_wrap", 32'(spike), 32'h1);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t3_any_high", 32'(spike_any), 1);
        end
        mode = 1'b1;
        step();
        mode = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // Asynchronous reset mid-activity, sampled without a clock edge.
        rst_n = 1'b0;
        #1;
        check("t1_async_spike", 32'(spike), 0);
        check("t1_async_any", 32'(spike_any), 0);
        check("t1_async_count", 32'(spike_count), 0);
        model_reset();
        #2;
        rst_n = 1'b1;

        // Saturation: 200 then 388 clamps to 255 and fires at threshold 255.
        setup(1'b0, 4'b0001, 8'd200, 8'd0, 8'd255);
        step();
        check("t4_no_spike", 32'(spike), 0);
        step();
        check("t4_sat_spike", 32'(spike), 32'h1);

        // All-to-all: three neurons kick the fourth with 3*60 = 180.
        do_reset();
        setup(1'b1, 4'b0111, 8'd150, 8'd60, 8'd150);
        step();
        check("t5_first", 32'(spike), 32'h7);
        stim = '0;
        step();
        check("t5_second", 32'(spike), 32'h8);
        step();
        check("t5_count", 32'(spike_count), 4);

        // Enable freeze: hold at v0=124, resume and fire on the second edge.
        do_reset();
        setup(1'b0, 4'b0001, 8'd64, 8'd0, 8'd200);
        step();
        step();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_frozen", 32'(spike), 0);
        end
        ena = 1'b1;
        step();
        check("t6_resume_quiet", 32'(spike), 0);
        step();
        check("t6_resume_spike", 32'(spike), 32'h1);

        // Drive the counter into saturation, then clear it with spikes present.
        do_reset();
        setup(1'b1, 4'b1111, 8'd200, 8'd255, 8'd200);
        for (int k = 0; k < 250; k++) step();
        check("t6_count_sat", 32'(spike_count), 255);
        for (int k = 0; k < 5 && spike == '0; k++) step();
        check("t6_spike_present", 32'(spike != '0), 1);
        count_clr = 1'b1;
        step();
        check("t6_count_clr", 32'(spike_count), 0);
        count_clr = 1'b0;
        for (int k = 0; k < 6; k++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lif_osc_network.md
Name: lif_osc_network

Overview:
- Parametrised successor to the fixed two-neuron/two-synapse network.
- N leaky integrate-and-fire neurons with configurable synaptic coupling, in ring or all-to-all topology, forming a spiking oscillator network.
- Neurons have per-neuron external stimulus, threshold, leak and refractory period.
- Outputs: registered spike vector, OR'd spike line and saturating spike counter; sits under the Tiny Tapeout top level.

Parameters:
- N, 4, number of neurons (2..8).
- W, 8, membrane-potential/weight/threshold width.
- LEAK_SHIFT, 4, leak = v >> LEAK_SHIFT per enabled cycle.
- REFRACT, 2, refractory cycles after a spike (0..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  network advance enable.
- mode  in  1  coupling topology: 0 = ring (i-1 drives i, neuron 0 driven by N-1), 1 = all-to-all.
- stim  in  N  per-neuron stimulus enable.
- stim_level  in  W  stimulus current added when stim[i]=1.
- coup_weight  in  W  synaptic weight per incoming spike.
- threshold  in  W  firing threshold; 0 disables firing.
- count_clr  in  1  synchronous clear of spike_count.
- spike  out  N  registered one-cycle spike pulses.
- spike_any  out  1  OR of spike (combinational from register).
- spike_count  out  8  total spikes emitted, saturating at 255.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all v[i]=0, refr[i]=0, spike=0, spike_count=0.
- ena=0: v and refr hold; spike register loads 0; count holds (count_clr still honoured).
- ena=1, per neuron i, each cycle:
  - Refractory: if refr[i]!=0, then refr[i]--, v[i]=0, spike[i]=0. Stimulus and coupling are ignored.
  - Otherwise, sum = v[i] - (v[i]>>LEAK_SHIFT) + (stim[i]?stim_level:0) + coup[i].
  - The sum is computed in W+4 bits, then saturated to 2^W-1. It never wraps.
- Coupling uses the previous cycle's spike register, so neuron-to-neuron latency is exactly 1 cycle.
  - Ring: coup[i] = spike[(i-1) mod N] ? coup_weight : 0.
  - All-to-all: coup[i] = popcount(spike & ~(1<<i)) * coup_weight. There is no self-coupling.
- Fire: if threshold!=0 and the saturated sum >= threshold, then spike[i]<=1, v[i]<=0, refr[i]<=REFRACT. Otherwise spike[i]<=0 and v[i]<=sum.
- The stimulus-to-spike path is registered: a spike appears the cycle after the qualifying edge.
- spike_count:
  - Each cycle, add popcount(spike) of the current register, saturating at 255.
  - count_clr=1 sets it to 0. count_clr has priority over the same-cycle increment.
- Simultaneous spikes on any number of neurons are all counted. In all-to-all mode they all contribute to coupling.
- mode may change at any cycle; the new topology takes effect on the next edge.
- Reset asserted mid-operation clears all state immediately (asynchronously). Deassertion restarts from v=0 with no spikes pending.

Test Plan:
Config for all scenarios: N=4, W=8, LEAK_SHIFT=4, REFRACT=2.
1. Reset: assert rst_n=0 during activity -> spike=0, spike_any=0, spike_count=0 without a clock edge.
2. Single-neuron integration: ena=1, stim=0001, stim_level=64, threshold=200, coup_weight=0 -> v0 = 64, 124, 181, then spike[0] on the 4th enabled cycle; 2 refractory cycles follow; period is 6 cycles; count +1 per period.
3. Ring oscillation:
   - Setup: mode=0, threshold=200, coup_weight=255.
   - Stimulus: stim=0001 with stim_level=200 for one cycle only.
   - Required: spikes on neurons 0,1,2,3,0,... on consecutive cycles, sustained with period 4; spike_any stays high.
4. Saturation: stim=0001, stim_level=200, threshold=255 -> v0 = 200, then 388 saturates to 255, so spike[0] on cycle 2. A wrapping implementation gives 132 and no spike.
5. All-to-all:
   - Setup: mode=1, coup_weight=60, threshold=150.
   - Stimulus: stim=0111 with stim_level=150 for one cycle.
   - Required: spike=0111 on cycle 1; neuron 3 receives 180 and spike=1000 on cycle 2; spike_count=4.
6. Enable and counter:
   - ena=0 mid-oscillation -> spike=0, v/refr frozen; re-enable and the pattern resumes from the frozen state.
   - Run until spike_count holds at 255.
   - count_clr together with spikes present -> spike_count=0.
